// File: rtl/mult_4x4_structural.sv
// Unsigned 4x4 array multiplier built from AND gates, half adders and full adders.
// Provides a combinational product and a registered copy with synchronous reset.
module mult_4x4_structural (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p,
   output logic [7:0] p_reg
);

   logic [3:0] pp [4];
   logic [3:0] s1, c1, s2, c2, s3, c3;
   logic [7:0] p_reg_d, p_reg_q;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp[i] = a & {4{b[i]}};
      end
   end

   // Row 1: pp0 bits 1..3 plus pp1 bits 0..3, spanning product bits 1..5
   half_adder u_r1_0 (.x(pp[0][1]), .y(pp[1][0]), .s(s1[0]), .c(c1[0]));
   full_adder u_r1_1 (.x(pp[0][2]), .y(pp[1][1]), .z(c1[0]), .s(s1[1]), .c(c1[1]));
   full_adder u_r1_2 (.x(pp[0][3]), .y(pp[1][2]), .z(c1[1]), .s(s1[2]), .c(c1[2]));
   half_adder u_r1_3 (.x(pp[1][3]), .y(c1[2]), .s(s1[3]), .c(c1[3]));

   half_adder u_r2_0 (.x(s1[1]), .y(pp[2][0]), .s(s2[0]), .c(c2[0]));
   full_adder u_r2_1 (.x(s1[2]), .y(pp[2][1]), .z(c2[0]), .s(s2[1]), .c(c2[1]));
   full_adder u_r2_2 (.x(s1[3]), .y(pp[2][2]), .z(c2[1]), .s(s2[2]), .c(c2[2]));
   full_adder u_r2_3 (.x(c1[3]), .y(pp[2][3]), .z(c2[2]), .s(s2[3]), .c(c2[3]));

   half_adder u_r3_0 (.x(s2[1]), .y(pp[3][0]), .s(s3[0]), .c(c3[0]));
   full_adder u_r3_1 (.x(s2[2]), .y(pp[3][1]), .z(c3[0]), .s(s3[1]), .c(c3[1]));
   full_adder u_r3_2 (.x(s2[3]), .y(pp[3][2]), .z(c3[1]), .s(s3[2]), .c(c3[2]));
   full_adder u_r3_3 (.x(c2[3]), .y(pp[3][3]), .z(c3[2]), .s(s3[3]), .c(c3[3]));

   assign p = {c3[3], s3, s2[0], s1[0], pp[0][0]};

   always_comb begin
      p_reg_d = p;
      if (rst) begin
         p_reg_d = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      p_reg_q <= p_reg_d;
   end

   assign p_reg = p_reg_q;

endmodule

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: tb/tb_mult_4x4_structural.sv
// Bench for mult_4x4_structural: directed table, exhaustive sweep,
// randomized register-path checks and reset sequences.
module tb_mult_4x4_structural;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] p;
   logic [7:0] p_reg;

   int n_run;
   int n_fail;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [9];

   mult_4x4_structural dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .p    (p),
      .p_reg(p_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model(input int x, input int y);
      int r;
      r = x * y;
      return r[7:0];
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp, input int x, input int y);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s a=%0d b=%0d got=%b want=%b", name, x, y, act, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_q;
      bit         stop;
      n_run  = 0;
      n_fail = 0;
      rst    = 1'b1;
      a      = 4'd0;
      b      = 4'd0;

      vecs[0] = '{4'd0,  4'd0,  8'd0};
      vecs[1] = '{4'd1,  4'd1,  8'd1};
      vecs[2] = '{4'd3,  4'd5,  8'd15};
      vecs[3] = '{4'd4,  4'd4,  8'd16};
      vecs[4] = '{4'd8,  4'd2,  8'd16};
      vecs[5] = '{4'd15, 4'd15, 8'b11100001};
      vecs[6] = '{4'd15, 4'd1,  8'd15};
      vecs[7] = '{4'd15, 4'd8,  8'd120};
      vecs[8] = '{4'd9,  4'd15, 8'd135};

      repeat (2) @(posedge clk);
      #1 chk("reset_preg", p_reg, 8'h00, a, b);

      // p must track inputs even while rst is high
      for (int i = 0; i < 9; i++) begin
         a = vecs[i].a;
         b = vecs[i].b;
         #10 chk("directed_p", p, vecs[i].exp, a, b);
      end

      stop = 1'b0;
      for (int x = 0; x < 16 && !stop; x++) begin
         for (int y = 0; y < 16 && !stop; y++) begin
            a = 4'(x);
            b = 4'(y);
            #10;
            if (p !== model(x, y)) stop = 1'b1;
            chk("exhaustive_p", p, model(x, y), x, y);
         end
      end

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("rst2_preg", p_reg, 8'h00, a, b);
      @(negedge clk);
      rst = 1'b0;
      a = 4'd7;
      b = 4'd6;
      #1 chk("p_immediate", p, 8'd42, a, b);
      chk("preg_before_edge", p_reg, 8'h00, a, b);
      @(posedge clk);
      #1 chk("preg_42", p_reg, 8'd42, a, b);

      // value captured at the edge survives an input change between edges
      @(negedge clk);
      a = 4'd2;
      b = 4'd3;
      #1 chk("preg_hold", p_reg, 8'd42, a, b);
      chk("p_between", p, 8'd6, a, b);
      @(posedge clk);
      #1 chk("preg_6", p_reg, 8'd6, a, b);

      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         exp_q = model(a, b);
         #1 chk("rand_p", p, exp_q, a, b);
         @(posedge clk);
         #1 chk("rand_preg", p_reg, exp_q, a, b);
      end

      @(negedge clk);
      a = 4'd15;
      b = 4'd15;
      @(posedge clk);
      #1 chk("ms_preg225", p_reg, 8'd225, a, b);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("ms_rst_preg", p_reg, 8'h00, a, b);
      chk("ms_rst_p", p, 8'd225, a, b);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("ms_resume", p_reg, 8'd225, a, b);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
